// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, controller state encodings and
// the opcode legality check used by the byte-stream controller.
package alu_pkg;

    localparam int NB_STATE = 3;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam logic [NB_STATE-1:0] ST_IDLE    = 3'd0;
    localparam logic [NB_STATE-1:0] ST_WAIT_B  = 3'd1;
    localparam logic [NB_STATE-1:0] ST_WAIT_OP = 3'd2;
    localparam logic [NB_STATE-1:0] ST_EXEC    = 3'd3;
    localparam logic [NB_STATE-1:0] ST_SEND    = 3'd4;
    localparam logic [NB_STATE-1:0] ST_WAIT_TX = 3'd5;

    function automatic logic is_valid_opcode(input logic [5:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_uart_interface_rx_timeout_counter.sv
// Inter-byte watchdog: o_terminal marks the cycle whose edge would bring the
// count to TIMEOUT_CYCLES-1, so that edge is the one that abandons the command.
module rx_timeout_counter #(
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [NB_TIMEOUT-1:0] TERMINAL_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 2);
    localparam logic [NB_TIMEOUT-1:0] COUNT_ONE      = NB_TIMEOUT'(1);

    logic [NB_TIMEOUT-1:0] r_count;

    // Idle-cycle counter; clear has priority over counting
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + COUNT_ONE;
        end
    end

    assign o_terminal = i_enable && (r_count == TERMINAL_COUNT);

endmodule

// File: rtl/alu_uart_interface.sv
// Sequences the shared combinational ALU from a UART byte stream
// (A, B, opcode) and hands the registered result to the UART transmitter.
module alu_uart_interface
    import alu_pkg::*;
#(
    parameter int NB_DATA_BUS    = 8,
    parameter int NB_OPCODE      = 6,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [NB_DATA_BUS-1:0] i_rx_data,
    input  logic                   i_rx_done,
    input  logic                   i_tx_done,
    input  logic [NB_DATA_BUS-1:0] i_alu_result,
    output logic [NB_DATA_BUS-1:0] o_alu_data_a,
    output logic [NB_DATA_BUS-1:0] o_alu_data_b,
    output logic [NB_OPCODE-1:0]   o_alu_opcode,
    output logic [NB_DATA_BUS-1:0] o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_error,
    output logic [NB_STATE-1:0]    o_state
);

    logic [NB_STATE-1:0]    r_state;
    logic [NB_DATA_BUS-1:0] r_data_a;
    logic [NB_DATA_BUS-1:0] r_data_b;
    logic [NB_OPCODE-1:0]   r_opcode;
    logic [NB_DATA_BUS-1:0] r_tx_data;
    logic                   r_tx_start;
    logic                   r_busy;
    logic                   r_error;

    logic [NB_STATE-1:0] w_next_state;
    logic                w_load_a;
    logic                w_load_b;
    logic                w_load_op;
    logic                w_capture;
    logic                w_error;
    logic                w_op_valid;
    logic                w_timeout;
    logic                w_to_clear;
    logic                w_to_enable;

    assign w_op_valid = (i_rx_data[NB_DATA_BUS-1:NB_OPCODE] == '0)
                     && is_valid_opcode(i_rx_data[NB_OPCODE-1:0]);

    // Only the operand-collection states are watched for stalls
    assign w_to_enable = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_to_clear  = (w_next_state != r_state) || i_rx_done;

    rx_timeout_counter #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_timeout_counter (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_to_clear),
        .i_enable   (w_to_enable),
        .o_terminal (w_timeout)
    );

    // Next-state and load decode; a received byte always outranks the timeout
    always_comb begin
        w_next_state = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_capture    = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    w_load_a     = 1'b1;
                    w_next_state = ST_WAIT_B;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    w_load_b     = 1'b1;
                    w_next_state = ST_WAIT_OP;
                end else if (w_timeout) begin
                    w_error      = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done && w_op_valid) begin
                    w_load_op    = 1'b1;
                    w_next_state = ST_EXEC;
                end else if (i_rx_done || w_timeout) begin
                    w_error      = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                w_capture    = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                w_next_state = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_TX;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, operand and output registers; strobes are registered from next state
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_opcode   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tx_start <= (w_next_state == ST_SEND);
            r_busy     <= (w_next_state != ST_IDLE);
            r_error    <= w_error;
            if (w_load_a) begin
                r_data_a <= i_rx_data;
            end
            if (w_load_b) begin
                r_data_b <= i_rx_data;
            end
            if (w_load_op) begin
                r_opcode <= i_rx_data[NB_OPCODE-1:0];
            end
            if (w_capture) begin
                r_tx_data <= i_alu_result;
            end
        end
    end

    assign o_alu_data_a = r_data_a;
    assign o_alu_data_b = r_data_b;
    assign o_alu_opcode = r_opcode;
    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;
    assign o_busy       = r_busy;
    assign o_error      = r_error;
    assign o_state      = r_state;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a behavioural ALU attached.
module tb_alu_uart_interface;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       error;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    alu_uart_interface #(
        .NB_DATA_BUS    (8),
        .NB_OPCODE      (6),
        .NB_TIMEOUT     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_alu_data_a (alu_a),
        .o_alu_data_b (alu_b),
        .o_alu_opcode (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_error      (error),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            6'b100000: alu_result = alu_a + alu_b;
            6'b100010: alu_result = alu_a - alu_b;
            6'b100100: alu_result = alu_a & alu_b;
            6'b100101: alu_result = alu_a | alu_b;
            6'b100110: alu_result = alu_a ^ alu_b;
            6'b000011: alu_result = 8'($signed(alu_a) >>> alu_b);
            6'b000010: alu_result = alu_a >> alu_b;
            6'b100111: alu_result = ~(alu_a | alu_b);
            default:   alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic       valid;
        logic [7:0] exp_tx;
        logic [5:0] exp_op;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is sampled
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     32'(alu_a),    32'h0);
        check({tag, "_b"},     32'(alu_b),    32'h0);
        check({tag, "_op"},    32'(alu_op),   32'h0);
        check({tag, "_tx"},    32'(tx_data),  32'h0);
        check({tag, "_start"}, 32'(tx_start), 32'h0);
        check({tag, "_busy"},  32'(busy),     32'h0);
        check({tag, "_err"},   32'(error),    32'h0);
        check({tag, "_state"}, 32'(state),    32'h0);
    endtask

    task automatic watch_no_start(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_start) seen++;
        end
        check(tag, 32'(seen), 32'h0);
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        send(v.a);
        check($sformatf("v%0d_st_b", idx), 32'(state), 32'd1);
        check($sformatf("v%0d_a", idx), 32'(alu_a), 32'(v.a));
        send(v.b);
        check($sformatf("v%0d_st_op", idx), 32'(state), 32'd2);
        check($sformatf("v%0d_b", idx), 32'(alu_b), 32'(v.b));
        send(v.op);
        if (v.valid) begin
            check($sformatf("v%0d_exec", idx), 32'(state), 32'd3);
            check($sformatf("v%0d_nostart", idx), 32'(tx_start), 32'h0);
            @(negedge clk);
            check($sformatf("v%0d_send", idx), 32'(state), 32'd4);
            check($sformatf("v%0d_start", idx), 32'(tx_start), 32'h1);
            check($sformatf("v%0d_tx", idx), 32'(tx_data), 32'(v.exp_tx));
            @(negedge clk);
            check($sformatf("v%0d_start_1cyc", idx), 32'(tx_start), 32'h0);
            check($sformatf("v%0d_waittx", idx), 32'(state), 32'd5);
            check($sformatf("v%0d_opc", idx), 32'(alu_op), 32'(v.exp_op));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_busy", idx), 32'(busy), 32'h1);
            check($sformatf("v%0d_tx_hold", idx), 32'(tx_data), 32'(v.exp_tx));
            pulse_tx_done();
            check($sformatf("v%0d_idle", idx), 32'(state), 32'd0);
            check($sformatf("v%0d_notbusy", idx), 32'(busy), 32'h0);
        end else begin
            check($sformatf("v%0d_inv_state", idx), 32'(state), 32'd0);
            check($sformatf("v%0d_inv_err", idx), 32'(error), 32'h1);
            check($sformatf("v%0d_inv_opc", idx), 32'(alu_op), 32'(v.exp_op));
            check($sformatf("v%0d_inv_a", idx), 32'(alu_a), 32'(v.a));
            @(negedge clk);
            check($sformatf("v%0d_err_1cyc", idx), 32'(error), 32'h0);
            watch_no_start($sformatf("v%0d_inv_nostart", idx), 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA0, 8'h0A, 8'h20, 1'b1, 8'hAA, 6'b100000};
        vecs[1] = '{8'h8B, 8'h02, 8'h03, 1'b1, 8'hE2, 6'b000011};
        vecs[2] = '{8'hA0, 8'h04, 8'h27, 1'b1, 8'h5B, 6'b100111};
        vecs[3] = '{8'h11, 8'h22, 8'h3F, 1'b0, 8'h00, 6'b100111};
        vecs[4] = '{8'h0F, 8'h33, 8'h24, 1'b1, 8'h03, 6'b100100};
        vecs[5] = '{8'h01, 8'h02, 8'h60, 1'b0, 8'h00, 6'b100100};
        vecs[6] = '{8'h3C, 8'h0F, 8'h26, 1'b1, 8'h33, 6'b100110};
        vecs[7] = '{8'h80, 8'h03, 8'h02, 1'b1, 8'h10, 6'b000010};

        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven commands, including invalid opcodes
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], i);
        end

        // Timeout in WAIT_B: error after 7 cycles there
        send(8'h55);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("to_wait_%0d", i), 32'(state), 32'd1);
        end
        check("to_noerr_early", 32'(error), 32'h0);
        @(negedge clk);
        check("to_state", 32'(state), 32'd0);
        check("to_err", 32'(error), 32'h1);
        check("to_a_kept", 32'(alu_a), 32'h55);
        @(negedge clk);
        send(8'h66);
        check("to_next_a", 32'(alu_a), 32'h66);
        check("to_next_st", 32'(state), 32'd1);

        // Byte on the terminal cycle wins
        repeat (6) @(negedge clk);
        send(8'h34);
        check("term_byte_st", 32'(state), 32'd2);
        check("term_byte_err", 32'(error), 32'h0);
        check("term_byte_b", 32'(alu_b), 32'h34);
        repeat (6) @(negedge clk);
        check("to_op_wait", 32'(state), 32'd2);
        @(negedge clk);
        check("to_op_state", 32'(state), 32'd0);
        check("to_op_err", 32'(error), 32'h1);
        @(negedge clk);

        // rx byte during WAIT_TX is dropped; tx_done outside WAIT_TX ignored
        send(8'h05);
        pulse_tx_done();
        check("txdone_ignored", 32'(state), 32'd1);
        send(8'h03);
        send(8'h20);
        repeat (2) @(negedge clk);
        check("drop_waittx", 32'(state), 32'd5);
        check("drop_tx", 32'(tx_data), 32'h08);
        send(8'h77);
        check("drop_still_wait", 32'(state), 32'd5);
        check("drop_a_kept", 32'(alu_a), 32'h05);
        pulse_tx_done();
        repeat (3) @(negedge clk);
        check("drop_idle", 32'(state), 32'd0);
        check("drop_a_not77", 32'(alu_a), 32'h05);
        send(8'h09);
        check("drop_new_a", 32'(alu_a), 32'h09);
        check("drop_new_st", 32'(state), 32'd1);

        // Reset in WAIT_OP
        send(8'h20);
        check("rst_op_pre", 32'(state), 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_all_zero("rst_op");
        watch_no_start("rst_op_nostart", 4);

        // Reset in SEND
        send(8'h10);
        send(8'h20);
        send(8'h20);
        @(negedge clk);
        check("rst_send_pre", 32'(tx_start), 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_all_zero("rst_send");
        watch_no_start("rst_send_nostart", 5);
        check("rst_send_idle", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Controller that sequences the shared 8-bit ALU from a byte stream (UART receiver) instead of push-buttons.
- Collects operand A, operand B and opcode bytes in that order, drives the ALU, captures the result and hands it to the UART transmitter with a start/done handshake.
- Sits between the UART rx/tx blocks and the ALU in the next toplevel; the ALU itself stays combinational and unchanged.

Parameters:
- NB_DATA_BUS, 8, width of operands, result and UART bytes.
- NB_OPCODE, 6, ALU opcode width.
- NB_TIMEOUT, 16, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 50000, idle cycles tolerated between bytes of one command (must be < 2**NB_TIMEOUT).

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_DATA_BUS  received byte, valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse from UART rx.
- i_tx_done  in  1  one-cycle pulse from UART tx when the byte has been sent.
- i_alu_result  in  NB_DATA_BUS  combinational ALU result.
- o_alu_data_a  out  NB_DATA_BUS  operand A to ALU.
- o_alu_data_b  out  NB_DATA_BUS  operand B to ALU.
- o_alu_opcode  out  NB_OPCODE  opcode to ALU.
- o_tx_data  out  NB_DATA_BUS  byte to transmit (registered result).
- o_tx_start  out  1  one-cycle start pulse to UART tx.
- o_busy  out  1  high in every state except IDLE.
- o_error  out  1  one-cycle pulse on invalid opcode or timeout.
- o_state  out  3  current state encoding, for debug LEDs.

Behaviour:
- Reset: sync active-low, only one clock. When i_reset_n=0 at a rising edge: state=IDLE; all outputs 0; timeout counter 0. Reset aborts any operation, and no o_tx_start follows.
- States: IDLE(0), WAIT_B(1), WAIT_OP(2), EXEC(3), SEND(4), WAIT_TX(5). Codes 6 and 7 go to IDLE.
- IDLE: on i_rx_done, o_alu_data_a<=i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_data_b<=i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, check the byte.
  - Valid: bits[7:6]==0 and bits[5:0] in {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111}. Then o_alu_opcode<=bits[5:0] and go to EXEC.
  - Invalid: o_error=1 for one cycle, o_alu_opcode unchanged, A/B unchanged, go to IDLE.
- EXEC: one cycle so the ALU settles. o_tx_data<=i_alu_result, go to SEND.
- SEND: o_tx_start=1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: hold o_tx_data. On i_tx_done go to IDLE. No timeout in this state.
- Latency: opcode i_rx_done at edge N gives EXEC in cycle N+1 and o_tx_start high in cycle N+2.
- Timeout:
  - Counter clears on every state change and on every i_rx_done.
  - It increments each cycle in WAIT_B and WAIT_OP.
  - When the count reaches TIMEOUT_CYCLES-1 without a byte: o_error pulses, state goes to IDLE, and the partial command is discarded (registers keep their values).
- Simultaneous events:
  - i_rx_done on the timeout terminal cycle: the byte wins and no error is raised.
  - i_rx_done in EXEC, SEND or WAIT_TX: ignored and dropped.
  - i_tx_done outside WAIT_TX: ignored.
- o_alu_* outputs hold their values between commands; the ALU output is not gated.

Decomposition:
- Shared package alu_pkg holds the opcode localparams (shared with the ALU), the state encodings and NB_STATE=3.
- One natural sub-module: rx_timeout_counter (clear, enable, terminal-count pulse; params NB_TIMEOUT, TIMEOUT_CYCLES).
- The FSM and registers stay in the top of this block.

Test Plan:
1. Release reset, then bytes 0xA0, 0x0A, 0x20 with the ALU model attached -> A=0xA0, B=0x0A, opcode=6'b100000. o_tx_data=0xAA. o_tx_start is high for 1 cycle, 2 cycles after the opcode rx_done. o_busy stays high until i_tx_done.
2. Bytes 0x8B, 0x02, 0x03 (SRA) -> o_tx_data=0xE2. Then 0xA0, 0x04, 0x27 (NOR) -> o_tx_data=0x5B.
3. Bytes 0x11, 0x22, 0x3F (invalid) -> o_error pulse, no o_tx_start, state IDLE, o_alu_opcode unchanged. The next valid command completes normally.
4. Byte 0x55, then no byte for TIMEOUT_CYCLES (use 8) -> o_error after 7 cycles in WAIT_B, state IDLE. The next byte loads A. Also check that a byte on the terminal cycle suppresses the error.
5. In WAIT_TX inject i_rx_done 0x77 before i_tx_done -> byte dropped. After i_tx_done, 0x77 is not taken as A; the next new byte is.
6. Drive i_reset_n=0 for one edge in WAIT_OP, and again in SEND -> all outputs 0, state IDLE, no o_tx_start afterwards.
